// File: rtl/riscv_pkg.sv
// riscv_pkg: shared datapath width, NOP encoding, opcode constants and fetch FSM encoding.
package riscv_pkg;
    localparam int XLEN = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_LW     = 7'b0000011;
    localparam logic [6:0] OP_SW     = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_ADDI3  = 7'b0010011;
    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_VALID = 2'd1,
        ST_TRAP  = 2'd2
    } fetch_state_e;
endpackage

// File: rtl/next_pc_logic.sv
// next_pc_logic: combinational next-PC selection (jalr > jal > taken branch > pc+4) and link value.
module next_pc_logic #(
    parameter int W = riscv_pkg::XLEN
) (
    input  logic [W-1:0] pc_i,
    input  logic [W-1:0] imm_i,
    input  logic [W-1:0] rs1_val_i,
    input  logic         branch_i,
    input  logic         jal_i,
    input  logic         jalr_i,
    input  logic         zero_i,
    output logic [W-1:0] next_pc_o,
    output logic [W-1:0] pc_plus4_o
);
    logic [W-1:0] jalr_sum;
    logic [W-1:0] pc_imm;
    logic         take_branch;

    assign jalr_sum    = rs1_val_i + imm_i;
    assign pc_imm      = pc_i + imm_i;
    // An unknown zero flag must never redirect fetch, so only a definite 1 takes the branch.
    assign take_branch = branch_i & (zero_i === 1'b1);
    assign pc_plus4_o  = pc_i + W'(4);
    assign next_pc_o   = jalr_i ? {jalr_sum[W-1:1], 1'b0}
                       : (jal_i | take_branch) ? pc_imm
                       : pc_plus4_o;
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: owns the PC, single-issue imem fetch over req/ack, holds instr for decode.
// Optional FETCH_MISALIGN_TRAP_EN: misaligned redirect enters a sticky TRAP state instead of aligning.
module instr_fetch_unit #(
    parameter int               XLEN     = riscv_pkg::XLEN,
    parameter logic [XLEN-1:0]  RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_rdata,
    output logic [31:0]     instr,
    output logic [6:0]      opCode,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    output logic            instr_valid,
    input  logic            retire,
    input  logic            stall,
    input  logic            branch,
    input  logic            jal,
    input  logic            jalr,
    input  logic            zero,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] rs1_val,
    output logic            misalign_trap
);
    import riscv_pkg::*;

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [31:0]     instr_q, instr_d;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] next_pc;
    logic            misaligned;

    next_pc_logic #(.W(XLEN)) u_next_pc (
        .pc_i       (pc_q),
        .imm_i      (imm),
        .rs1_val_i  (rs1_val),
        .branch_i   (branch),
        .jal_i      (jal),
        .jalr_i     (jalr),
        .zero_i     (zero),
        .next_pc_o  (target),
        .pc_plus4_o (pc_plus4)
    );

`ifdef FETCH_MISALIGN_TRAP_EN
    assign next_pc       = target;
    assign misaligned    = |target[1:0];
    assign misalign_trap = (state_q == ST_TRAP);
`else
    assign next_pc       = target & ~XLEN'(3);
    assign misaligned    = 1'b0;
    assign misalign_trap = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        case (state_q)
            ST_FETCH: if (imem_ack) begin
                instr_d = imem_rdata;
                state_d = ST_VALID;
            end
            // stall outranks retire; ack arriving here is ignored
            ST_VALID: if (retire && !stall) begin
                pc_d    = next_pc;
                state_d = misaligned ? ST_TRAP : ST_FETCH;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_FETCH;
            pc_q    <= RESET_PC;
            instr_q <= NOP_INSTR;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    // Request is masked while reset is held so an abandoned fetch never leaks out.
    assign imem_req    = (state_q == ST_FETCH) & ~reset;
    assign imem_addr   = pc_q;
    assign instr       = instr_q;
    assign opCode      = instr_q[6:0];
    assign pc          = pc_q;
    assign instr_valid = (state_q == ST_VALID);
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: scoreboard bench with an imem responder, directed cases and random traffic.
module tb_instr_fetch_unit;
    logic        clk = 1'b0, reset = 1'b1;
    logic        imem_req, imem_ack = 1'b0, instr_valid, misalign_trap;
    logic        retire = 1'b0, stall = 1'b0, branch = 1'b0, jal = 1'b0, jalr = 1'b0, zero = 1'b0;
    logic [31:0] imem_addr, imem_rdata = '0, instr, pc, pc_plus4, imm = '0, rs1_val = '0;
    logic [6:0]  opCode;
    int          checks = 0, errors = 0;
    logic [31:0] m_pc = '0, m_ins = 32'h0000_0013, nxt;
    logic        prev_valid = 1'b0;
    logic [6:0]  ops [5] = '{7'b0110011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b0010011};

    typedef struct {logic [31:0] ins; logic [31:0] addr;} exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    instr_fetch_unit dut (
        .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr(instr), .opCode(opCode),
        .pc(pc), .pc_plus4(pc_plus4), .instr_valid(instr_valid), .retire(retire),
        .stall(stall), .branch(branch), .jal(jal), .jalr(jalr), .zero(zero),
        .imm(imm), .rs1_val(rs1_val), .misalign_trap(misalign_trap)
    );

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // Next PC straight from the architectural rules, before any alignment handling.
    function automatic logic [31:0] ref_next(input logic [31:0] p, input logic jr, j, b, z,
                                             input logic [31:0] im, rs);
        if (jr) return (rs + im) / 2 * 2;
        if (j || (b && z)) return p + im;
        return p + 4;
    endfunction

    always @(negedge clk) begin : monitor
        exp_t e;
        if (instr_valid && !prev_valid) begin
            if (sb.size() == 0) begin
                checks++; errors++;
                $display("FAIL sb_unexpected: instr_valid rose with pc %h, no fetch outstanding", pc);
            end else begin
                e = sb.pop_front();
                chk("sb_instr", instr, e.ins);
                chk("sb_pc", pc, e.addr);
                chk("sb_opcode", 32'(opCode), 32'(e.ins[6:0]));
                chk("sb_pc_plus4", pc_plus4, e.addr + 32'd4);
            end
        end
        prev_valid <= instr_valid;
    end

    task automatic fetch(input logic [31:0] d, input int dly, input logic [31:0] exp_addr);
        int n = 0;
        while (!imem_req && n < 20) begin @(negedge clk); n++; end
        checks++;
        if (!imem_req) begin
            errors++;
            $display("FAIL req_timeout: imem_req=0 after %0d cycles, required 1", n);
            return;
        end
        chk("imem_addr", imem_addr, exp_addr);
        repeat (dly) begin
            @(negedge clk);
            chk("addr_hold", imem_addr, exp_addr);
            chk("req_hold", 32'(imem_req), 32'd1);
        end
        imem_ack = 1'b1; imem_rdata = d;
        sb.push_back('{ins: d, addr: exp_addr});
        @(negedge clk);
        imem_ack = 1'b0; imem_rdata = $urandom;
        chk("valid_latency", 32'(instr_valid), 32'd1);
        m_pc = exp_addr; m_ins = d;
    endtask

    task automatic retire_op(input logic jr, j, b, z, input logic [31:0] im, rs, input int stalls,
                             output logic [31:0] t);
        jalr = jr; jal = j; branch = b; zero = z; imm = im; rs1_val = rs;
        chk("pc_plus4_valid", pc_plus4, m_pc + 32'd4);
        retire = 1'b1; stall = 1'b1;
        repeat (stalls) begin
            imem_ack = 1'b1; imem_rdata = $urandom;
            @(negedge clk);
            chk("stall_valid", 32'(instr_valid), 32'd1);
            chk("stall_req", 32'(imem_req), 32'd0);
            chk("stall_pc", pc, m_pc);
            chk("stall_instr", instr, m_ins);
        end
        imem_ack = 1'b0; stall = 1'b0;
        t = ref_next(m_pc, jr, j, b, z, im, rs);
`ifndef FETCH_MISALIGN_TRAP_EN
        t = t - t % 4;
`endif
        @(negedge clk);
        retire = 1'b0; jalr = 1'b0; jal = 1'b0; branch = 1'b0; zero = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_instr", instr, 32'h0000_0013);
        chk("rst_pc", pc, 32'h0);
        chk("rst_trap", 32'(misalign_trap), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        m_pc = '0;
    endtask

`ifdef FETCH_MISALIGN_TRAP_EN
    task automatic expect_trap(input logic [31:0] t);
        repeat (3) begin
            chk("trap_flag", 32'(misalign_trap), 32'd1);
            chk("trap_req", 32'(imem_req), 32'd0);
            chk("trap_valid", 32'(instr_valid), 32'd0);
            chk("trap_pc", pc, t);
            imem_ack = 1'b1;
            @(negedge clk);
        end
        imem_ack = 1'b0;
        do_reset();
    endtask
`endif

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin : stim
        logic [31:0] r, d, im, rs;
        logic        jr, j, b, z;
        repeat (2) @(negedge clk);
        chk("init_req", 32'(imem_req), 32'd0);
        chk("init_instr", instr, 32'h0000_0013);
        chk("init_valid", 32'(instr_valid), 32'd0);
        reset = 1'b0;
        fetch(32'h0000_0033, 2, 32'h0);
        chk("opcode_r", 32'(opCode), 32'h33);
        retire_op(0, 0, 0, 0, 0, 0, 0, nxt);
        fetch($urandom, 0, 32'h4);
        retire_op(1, 0, 0, 0, 32'h4, 32'hFFFF_FFF8, 0, nxt);
        fetch($urandom, 1, 32'hFFFF_FFFC);
        chk("pc_plus4_wrap", pc_plus4, 32'h0);
        retire_op(0, 0, 0, 0, 0, 0, 0, nxt);
        fetch($urandom, 0, 32'h0);
        retire_op(1, 0, 0, 0, 32'h0, 32'h100, 0, nxt);
        fetch($urandom, 0, 32'h100);
        retire_op(0, 0, 1, 1, 32'hFFFF_FFF8, 0, 0, nxt);
        fetch($urandom, 0, 32'hF8);
        retire_op(1, 0, 0, 0, 32'h0, 32'h100, 0, nxt);
        fetch($urandom, 0, 32'h100);
        retire_op(0, 0, 1, 0, 32'hFFFF_FFF8, 0, 0, nxt);
        fetch($urandom, 0, 32'h104);
        retire_op(1, 1, 0, 0, 32'h4, 32'h203, 0, nxt);
`ifdef FETCH_MISALIGN_TRAP_EN
        expect_trap(32'h206);
        fetch($urandom, 0, 32'h0);
`else
        fetch($urandom, 0, 32'h204);
`endif
        retire_op(0, 0, 0, 0, 0, 0, 3, nxt);
        fetch($urandom, 1, nxt);
        retire_op(0, 1, 0, 0, 32'h2, 0, 0, nxt);
`ifdef FETCH_MISALIGN_TRAP_EN
        expect_trap(m_pc + 32'd2);
        fetch($urandom, 0, 32'h0);
`else
        fetch($urandom, 0, m_pc);
`endif
        retire_op(0, 0, 0, 0, 0, 0, 0, nxt);
        @(negedge clk);
        do_reset();
        fetch($urandom, 0, 32'h0);
        for (int i = 0; i < 40; i++) begin
            r = $urandom;
            d = {r[31:7], ops[$urandom_range(0, 4)]};
            jr = ($urandom_range(0, 3) == 0); j = ($urandom_range(0, 3) == 0);
            b = $urandom_range(0, 1) == 1;    z = $urandom_range(0, 1) == 1;
            im = $urandom; rs = $urandom;
`ifdef FETCH_MISALIGN_TRAP_EN
            im = im & ~32'd3; rs = rs & ~32'd3;
`endif
            retire_op(jr, j, b, z, im, rs, $urandom_range(0, 2), nxt);
            fetch(d, $urandom_range(0, 3), nxt);
        end
        repeat (3) @(negedge clk);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
